stream_unpack_bitrev: RTL and testbench
=======================================

Name: stream_unpack_bitrev

Overview:
- Receive-side counterpart of the streaming-operator bit-reverse path: deserializes a 1-bit serial stream into WIDTH-bit words.
- Optionally applies a SLICE-granular streaming reversal (`{<<SLICE{}}` semantics) to each assembled word before presenting it.
- Sits between a serial link/shift source and word-wide consumers; the transmit side packs words with the same reversal, so that the round trip is identity.

Parameters:
- WIDTH, 32, word width in bits; ≥2; WIDTH % SLICE == 0.
- SLICE, 1, reversal chunk size in bits; bit order inside a chunk is preserved.
- MSB_FIRST, 1, 1: first serial bit lands at bit WIDTH-1; 0: first bit lands at bit 0.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rev_en  input  1  reversal enable; sampled with the first bit of each word.
- s_valid  input  1  serial bit valid.
- s_data  input  1  serial bit.
- s_last  input  1  marks final bit of a (possibly partial) word.
- s_ready  output  1  bit accepted when s_valid&&s_ready.
- m_valid  output  1  output word valid.
- m_data  output  WIDTH  assembled (optionally reversed) word.
- m_nbits  output  $clog2(WIDTH+1)  number of received bits in m_data (WIDTH for full word).
- m_ready  input  1  consumer accepts when m_valid&&m_ready.

Behaviour:
- Reset (async assert, sync release): m_valid=0, m_data=0, m_nbits=0, s_ready=1, bit counter=0, shift reg=0, state FILL.
- Datapath: shift register plus bit counter (0..WIDTH-1). Output holding register drives m_*.
- Bit placement:
  - MSB_FIRST=1: shift left and insert at the LSB.
  - MSB_FIRST=0: shift right and insert at the MSB.
- Word completion: a bit is accepted with count==WIDTH-1, or with s_last=1.
- Partial word (s_last at count k-1 < WIDTH-1): align bits as if zeros were appended for the missing bits. The first bit sits where it would sit in a full word; unfilled positions are 0. m_nbits=k.
- Reversal: if rev_en was latched at the word's first bit, output chunk i = input chunk (WIDTH/SLICE-1-i). Reversal is applied after alignment. rev_en changes mid-word are ignored.
- State FILL:
  - s_ready=1.
  - On completion, if the output register is empty or drains this cycle (m_ready&&m_valid), load it: m_valid=1 next cycle, counter=0, stay FILL.
  - Otherwise go to FULL.
- State FULL:
  - s_ready=0; the completed word is held.
  - When the output drains, load the held word, return to FILL, s_ready=1 the next cycle.
- Latency: completing bit accepted in cycle N → m_valid=1 and m_data valid in cycle N+1.
- Throughput: 1 bit/clk sustained while m_ready=1. A full word can accumulate while the previous output is stalled, giving zero bubble.
- Output hold: m_data/m_nbits stable while m_valid&&!m_ready. m_valid drops the cycle after a handshake unless a new word loads in the same edge (back-to-back valid).
- Simultaneous drain + completion in FILL: load the new word, no bubble.
- s_last together with count==WIDTH-1: treated as a full word, m_nbits=WIDTH.
- s_valid=0: counter and shift register hold. Gaps inside a word are legal.
- Reset mid-word or mid-stall: all partial and held data are discarded; the block returns to reset values immediately.

Test Plan:
- Full word, reversal: WIDTH=32, SLICE=1, MSB_FIRST=1, rev_en=1, stream 0x01234567 MSB-first → m_data=0xE6A2C480, m_nbits=32, m_valid at cycle after bit 32. Then 0x89ABCDEF → 0xF7B3D591.
- Pass-through and byte slice: rev_en=0, 0x01234567 → 0x01234567. Same stream with SLICE=8, rev_en=1 → 0x67452301.
- LSB-first: MSB_FIRST=0, rev_en=0, stream bits of 0x89ABCDEF LSB-first → 0x89ABCDEF.
- Backpressure:
  - Hold m_ready=0 over three consecutive words: word 1 is held stable, word 2 fills, and s_ready drops after word 2 completes.
  - Raise m_ready: word 1 handshakes, word 2 loads on the same edge, s_ready returns to 1.
  - No word is lost or reordered.
- Partial word: MSB_FIRST=1, rev_en=0, 4 bits 1,0,1,1 with s_last on the 4th → m_data=0xB0000000, m_nbits=4. With rev_en=1 → 0x0000000D.
- Reset mid-operation: assert rst_n=0 after 17 bits with a word stalled at the output → m_valid=0, s_ready=1 asynchronously. The next full word after release decodes correctly.

Source files
------------

// File: rtl/stream_unpack_bitrev_if.sv
// Bundle for the serial bit input and word-wide output of stream_unpack_bitrev.
// The slave view belongs to the unpacker; the master view belongs to whatever drives it.
interface stream_unpack_bitrev_if #(
  parameter int WIDTH = 32
);
  localparam int NBW = $clog2(WIDTH + 1);

  logic             rev_en;
  logic             s_valid;
  logic             s_data;
  logic             s_last;
  logic             s_ready;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic [NBW-1:0]   m_nbits;
  logic             m_ready;

  modport master (
    output rev_en, s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_nbits
  );

  modport slave (
    input  rev_en, s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_nbits
  );
endinterface

// File: rtl/stream_unpack_bitrev.sv
// Deserializes a 1-bit stream into WIDTH-bit words, with optional SLICE-granular
// reversal of each word, and a one-word skid so one word can fill while the output stalls.
module stream_unpack_bitrev #(
  parameter int WIDTH     = 32,
  parameter int SLICE     = 1,
  parameter int MSB_FIRST = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  stream_unpack_bitrev_if.slave bus
);
  localparam int CW     = $clog2(WIDTH);
  localparam int NBW    = $clog2(WIDTH + 1);
  localparam int NCHUNK = WIDTH / SLICE;

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic             rev_reg, rev_next;
  logic [WIDTH-1:0] held_data_reg, held_data_next;
  logic [NBW-1:0]   held_nbits_reg, held_nbits_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic [NBW-1:0]   out_nbits_reg, out_nbits_next;
  logic             out_valid_reg, out_valid_next;

  logic             accept, complete, drain, out_free, rev_flag;
  logic [CW-1:0]    shamt;
  logic [WIDTH-1:0] shift_in, aligned, reversed, word;
  logic [NBW-1:0]   nbits;

  assign accept   = bus.s_valid && (state_reg == FILL);
  assign complete = accept && (bus.s_last || (cnt_reg == CW'(WIDTH - 1)));
  assign drain    = out_valid_reg && bus.m_ready;
  assign out_free = !out_valid_reg || bus.m_ready;
  assign rev_flag = (cnt_reg == '0) ? bus.rev_en : rev_reg;
  assign nbits    = NBW'(cnt_reg) + NBW'(1);
  // Distance between the bits received so far and their full-word positions.
  assign shamt    = CW'(WIDTH - 1) - cnt_reg;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign shift_in = {shift_reg[WIDTH-2:0], bus.s_data};
      assign aligned  = shift_in << shamt;
    end else begin : g_lsb
      assign shift_in = {bus.s_data, shift_reg[WIDTH-1:1]};
      assign aligned  = shift_in >> shamt;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_rev
      assign reversed[gi*SLICE +: SLICE] = aligned[(NCHUNK-1-gi)*SLICE +: SLICE];
    end
  endgenerate

  assign word = rev_flag ? reversed : aligned;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    shift_next      = shift_reg;
    rev_next        = rev_reg;
    held_data_next  = held_data_reg;
    held_nbits_next = held_nbits_reg;
    out_data_next   = out_data_reg;
    out_nbits_next  = out_nbits_reg;
    out_valid_next  = out_valid_reg;
    if (drain) out_valid_next = 1'b0;
    case (state_reg)
      FILL: begin
        if (accept) begin
          shift_next = shift_in;
          cnt_next   = cnt_reg + CW'(1);
          if (cnt_reg == '0) rev_next = bus.rev_en;
          if (complete) begin
            shift_next = '0;
            cnt_next   = '0;
            if (out_free) begin
              out_data_next  = word;
              out_nbits_next = nbits;
              out_valid_next = 1'b1;
            end else begin
              held_data_next  = word;
              held_nbits_next = nbits;
              state_next      = FULL;
            end
          end
        end
      end
      FULL: begin
        if (drain) begin
          out_data_next  = held_data_reg;
          out_nbits_next = held_nbits_reg;
          out_valid_next = 1'b1;
          state_next     = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= FILL;
      cnt_reg        <= '0;
      shift_reg      <= '0;
      rev_reg        <= 1'b0;
      held_data_reg  <= '0;
      held_nbits_reg <= '0;
      out_data_reg   <= '0;
      out_nbits_reg  <= '0;
      out_valid_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      shift_reg      <= shift_next;
      rev_reg        <= rev_next;
      held_data_reg  <= held_data_next;
      held_nbits_reg <= held_nbits_next;
      out_data_reg   <= out_data_next;
      out_nbits_reg  <= out_nbits_next;
      out_valid_reg  <= out_valid_next;
    end
  end

  assign bus.s_ready = (state_reg == FILL);
  assign bus.m_valid = out_valid_reg;
  assign bus.m_data  = out_data_reg;
  assign bus.m_nbits = out_nbits_reg;
endmodule

// File: tb/tb_stream_unpack_bitrev.sv
// Scoreboard bench: three unpacker configurations (bit reverse MSB-first, byte reverse,
// LSB-first) share one bit driver; a negedge monitor pops expected words on each handshake.
module tb_stream_unpack_bitrev;
  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  nbits;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic drv_valid = 1'b0, drv_data = 1'b0, drv_last = 1'b0, drv_rev = 1'b0, drv_ready = 1'b1;
  int   sel = 0;
  int   n_vec = 0, n_err = 0;
  exp_t q0[$], q1[$], q2[$];
  logic cur_s_ready;

  always #5 clk = ~clk;

  stream_unpack_bitrev_if #(.WIDTH(32)) if0 ();
  stream_unpack_bitrev_if #(.WIDTH(32)) if1 ();
  stream_unpack_bitrev_if #(.WIDTH(32)) if2 ();

  assign if0.s_valid = drv_valid && (sel == 0);
  assign if1.s_valid = drv_valid && (sel == 1);
  assign if2.s_valid = drv_valid && (sel == 2);
  assign if0.s_data = drv_data;  assign if1.s_data = drv_data;  assign if2.s_data = drv_data;
  assign if0.s_last = drv_last;  assign if1.s_last = drv_last;  assign if2.s_last = drv_last;
  assign if0.rev_en = drv_rev;   assign if1.rev_en = drv_rev;   assign if2.rev_en = drv_rev;
  assign if0.m_ready = drv_ready; assign if1.m_ready = drv_ready; assign if2.m_ready = drv_ready;
  assign cur_s_ready = (sel == 0) ? if0.s_ready : (sel == 1) ? if1.s_ready : if2.s_ready;

  stream_unpack_bitrev #(.WIDTH(32), .SLICE(1), .MSB_FIRST(1)) u_bit (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  stream_unpack_bitrev #(.WIDTH(32), .SLICE(8), .MSB_FIRST(1)) u_byte (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  stream_unpack_bitrev #(.WIDTH(32), .SLICE(1), .MSB_FIRST(0)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end else begin
      $display("check %s ok value=%h", name, act);
    end
  endtask

  task automatic check_out(input int k, input logic [31:0] d, input logic [5:0] n);
    exp_t e;
    bit found;
    found = 1'b1;
    e = '0;
    case (k)
      0: if (q0.size() != 0) e = q0.pop_front(); else found = 1'b0;
      1: if (q1.size() != 0) e = q1.pop_front(); else found = 1'b0;
      default: if (q2.size() != 0) e = q2.pop_front(); else found = 1'b0;
    endcase
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL out%0d unexpected word data=%h nbits=%0d expected none", k, d, n);
    end else if (d !== e.data || n !== e.nbits) begin
      n_err++;
      $display("FAIL out%0d data=%h nbits=%0d expected data=%h nbits=%0d", k, d, n, e.data, e.nbits);
    end else begin
      $display("out%0d word ok data=%h nbits=%0d", k, d, n);
    end
  endtask

  // Monitor: a valid&&ready seen at the falling edge handshakes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if0.m_valid && if0.m_ready) check_out(0, if0.m_data, if0.m_nbits);
      if (if1.m_valid && if1.m_ready) check_out(1, if1.m_data, if1.m_nbits);
      if (if2.m_valid && if2.m_ready) check_out(2, if2.m_data, if2.m_nbits);
    end
  end

  task automatic send_bit(input logic d, input logic last, input logic rev);
    int waitc;
    waitc = 0;
    drv_valid = 1'b1; drv_data = d; drv_last = last; drv_rev = rev;
    @(negedge clk);
    while (!cur_s_ready) begin
      waitc++;
      if (waitc > 200) begin
        n_vec++; n_err++;
        $display("FAIL s_ready_timeout actual=0 expected=1 within 200 cycles");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    drv_valid = 1'b0; drv_last = 1'b0;
  endtask

  // Sends n bits of w in the selected DUT's stream order; rev_en is inverted after the
  // first bit so any mid-word sampling shows up as a wrong word.
  task automatic send_word(input logic [31:0] w, input int n, input logic rev, input logic last_full,
                           input logic push, input logic [31:0] ed, input logic [5:0] en);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      logic b;
      b = (sel == 2) ? w[i] : w[31-i];
      send_bit(b, (i == n - 1) && (n < 32 || last_full), (i == 0) ? rev : !rev);
    end
    if (push) begin
      e.data = ed; e.nbits = en;
      case (sel)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout pending=%0d expected=0", q0.size() + q1.size() + q2.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_m_valid", 32'(if0.m_valid), 32'h0);
    cmp("reset_m_data", if0.m_data, 32'h0);
    cmp("reset_m_nbits", 32'(if0.m_nbits), 32'h0);
    cmp("reset_s_ready", 32'(if0.s_ready), 32'h1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    sel = 0;
    send_word(32'h01234567, 32, 1'b1, 1'b0, 1'b1, 32'hE6A2C480, 6'd32);
    cmp("latency_m_valid", 32'(if0.m_valid), 32'h1);
    send_word(32'h89ABCDEF, 32, 1'b1, 1'b1, 1'b1, 32'hF7B3D591, 6'd32);
    send_word(32'h01234567, 32, 1'b0, 1'b0, 1'b1, 32'h01234567, 6'd32);
    send_word(32'hB0000000, 4, 1'b0, 1'b0, 1'b1, 32'hB0000000, 6'd4);
    send_word(32'hB0000000, 4, 1'b1, 1'b0, 1'b1, 32'h0000000D, 6'd4);
    wait_drain();

    sel = 1;
    send_word(32'h01234567, 32, 1'b1, 1'b0, 1'b1, 32'h67452301, 6'd32);
    send_word(32'h01234567, 32, 1'b0, 1'b0, 1'b1, 32'h01234567, 6'd32);
    wait_drain();

    sel = 2;
    send_word(32'h89ABCDEF, 32, 1'b0, 1'b0, 1'b1, 32'h89ABCDEF, 6'd32);
    send_word(32'h89ABCDEF, 32, 1'b1, 1'b0, 1'b1, 32'hF7B3D591, 6'd32);
    send_word(32'h0000000B, 4, 1'b0, 1'b0, 1'b1, 32'h0000000B, 6'd4);
    wait_drain();

    // Backpressure: word 1 parks at the output, word 2 fills behind it.
    sel = 0;
    drv_ready = 1'b0;
    send_word(32'h01234567, 32, 1'b0, 1'b0, 1'b1, 32'h01234567, 6'd32);
    send_word(32'h89ABCDEF, 32, 1'b0, 1'b0, 1'b1, 32'h89ABCDEF, 6'd32);
    cmp("stall_s_ready", 32'(if0.s_ready), 32'h0);
    cmp("stall_hold_data", if0.m_data, 32'h01234567);
    repeat (3) @(posedge clk);
    #1;
    cmp("stall_hold_data_later", if0.m_data, 32'h01234567);
    cmp("stall_hold_valid", 32'(if0.m_valid), 32'h1);
    drv_ready = 1'b1;
    @(posedge clk);
    #1;
    cmp("release_s_ready", 32'(if0.s_ready), 32'h1);
    cmp("release_next_data", if0.m_data, 32'h89ABCDEF);
    cmp("release_next_valid", 32'(if0.m_valid), 32'h1);
    send_word(32'h00FF00FF, 32, 1'b1, 1'b0, 1'b1, 32'hFF00FF00, 6'd32);
    wait_drain();

    // Reset with a word stalled at the output and 17 bits of the next one in flight.
    drv_ready = 1'b0;
    send_word(32'h12345678, 32, 1'b0, 1'b0, 1'b0, 32'h0, 6'd0);
    send_word(32'hFFFF8000, 17, 1'b0, 1'b1, 1'b0, 32'h0, 6'd0);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_reset_m_valid", 32'(if0.m_valid), 32'h0);
    cmp("async_reset_s_ready", 32'(if0.s_ready), 32'h1);
    cmp("async_reset_m_data", if0.m_data, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drv_ready = 1'b1;
    @(posedge clk);
    #1;
    send_word(32'h89ABCDEF, 32, 1'b1, 1'b0, 1'b1, 32'hF7B3D591, 6'd32);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
